// File: rtl/apb_pkg.sv
// Shared APB completer definitions.
//   apb_slv_state_e : completer FSM state encoding
//   APB_AW / APB_DW : bus address / data widths
//   addr_err()      : 1 when a byte address falls outside the word window
//                     [base, base + 4*depth) or is not word aligned
package apb_pkg;

   localparam int APB_AW = 32;
   localparam int APB_DW = 32;

   typedef enum logic [1:0] {IDLE, WAIT, DONE} apb_slv_state_e;

   function automatic logic addr_err(input logic [APB_AW-1:0] paddr,
                                     input logic [APB_AW-1:0] base,
                                     input logic [APB_AW-1:0] depth);
      logic [APB_AW-1:0] off;
      off = paddr - base;
      return (paddr < base) || ((off >> 2) >= depth) || (paddr[1:0] != 2'b00);
   endfunction

endpackage

// File: rtl/apb_slave_regfile.sv
// Word memory behind the APB completer.
//   clk    : clock, writes on posedge
//   rst_n  : asynchronous active-low clear of every word
//   we     : write enable
//   addr   : word index, shared by the write and read ports
//   wdata  : write data
//   rdata  : combinational read of mem[addr]
module apb_slave_regfile #(
   parameter int DEPTH = 16,
   parameter int DW    = 32,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem_q [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q <= '{default: '0};
      end else if (we) begin
         mem_q[addr] <= wdata;
      end
   end

   assign rdata = mem_q[addr];

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer backing a DEPTH x 32-bit memory, with a fixed number of
// PREADY-low wait states per transfer and PSLVERR on illegal addresses.
//   clk      : bus clock
//   PRESETn  : asynchronous active-low reset (clears outputs and memory)
//   PSEL1    : slave select
//   PENABLE  : access phase strobe
//   PWRITE   : 1 = write, 0 = read
//   PADDR    : byte address
//   PWDATA   : write data
//   PRDATA   : read data (registered)
//   PREADY   : transfer complete (registered)
//   PSLVERR  : error response (registered)
//
// state | meaning
// IDLE  | waiting for a setup phase
// WAIT  | access phase, PREADY low, wait counter running down
// DONE  | access phase, PREADY high with response loaded
module apb_slave_mem
   import apb_pkg::*;
#(
   parameter int                DEPTH       = 16,
   parameter int                WAIT_CYCLES = 2,
   parameter logic [APB_AW-1:0] BASE_ADDR   = '0
) (
   input  logic              clk,
   input  logic              PRESETn,
   input  logic              PSEL1,
   input  logic              PENABLE,
   input  logic              PWRITE,
   input  logic [APB_AW-1:0] PADDR,
   input  logic [APB_DW-1:0] PWDATA,
   output logic [APB_DW-1:0] PRDATA,
   output logic              PREADY,
   output logic              PSLVERR
);

   localparam int IDXW = $clog2(DEPTH);
   localparam int CW   = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

   apb_slv_state_e    state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              pready_q, pready_d;
   logic              pslverr_q, pslverr_d;
   logic [APB_DW-1:0] prdata_q, prdata_d;

   logic              acc_err;
   logic [IDXW-1:0]   idx;
   logic              mem_we;
   logic [APB_DW-1:0] mem_rdata;
   logic [APB_DW-1:0] resp_rdata;

   // idx is only meaningful when acc_err is 0; out-of-range addresses never
   // reach the memory write port.
   assign acc_err    = addr_err(PADDR, BASE_ADDR, APB_AW'(DEPTH));
   assign idx        = IDXW'((PADDR - BASE_ADDR) >> 2);
   assign resp_rdata = (PWRITE || acc_err) ? '0 : mem_rdata;

   apb_slave_regfile #(
      .DEPTH (DEPTH),
      .DW    (APB_DW)
   ) u_regfile (
      .clk   (clk),
      .rst_n (PRESETn),
      .we    (mem_we),
      .addr  (idx),
      .wdata (PWDATA),
      .rdata (mem_rdata)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pready_d  = pready_q;
      pslverr_d = pslverr_q;
      prdata_d  = prdata_q;
      mem_we    = 1'b0;

      if (PSEL1 && !PENABLE) begin
         // A setup phase restarts the transfer from any state.
         if (WAIT_CYCLES == 0) begin
            state_d   = DONE;
            cnt_d     = '0;
            pready_d  = 1'b1;
            pslverr_d = acc_err;
            prdata_d  = resp_rdata;
         end else begin
            state_d   = WAIT;
            cnt_d     = CW'(WAIT_CYCLES - 1);
            pready_d  = 1'b0;
            pslverr_d = 1'b0;
            prdata_d  = '0;
         end
      end else if (!PSEL1) begin
         // Idle bus, or the master aborted: drop everything, no write.
         state_d   = IDLE;
         cnt_d     = '0;
         pready_d  = 1'b0;
         pslverr_d = 1'b0;
         prdata_d  = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               // Access strobe without a setup phase is ignored.
            end
            WAIT: begin
               if (cnt_q == '0) begin
                  state_d   = DONE;
                  pready_d  = 1'b1;
                  pslverr_d = acc_err;
                  prdata_d  = resp_rdata;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            DONE: begin
               mem_we    = PWRITE && !acc_err;
               state_d   = IDLE;
               cnt_d     = '0;
               pready_d  = 1'b0;
               pslverr_d = 1'b0;
               prdata_d  = '0;
            end
            default: begin
               state_d   = IDLE;
               cnt_d     = '0;
               pready_d  = 1'b0;
               pslverr_d = 1'b0;
               prdata_d  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         prdata_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
         prdata_q  <= prdata_d;
      end
   end

   assign PREADY  = pready_q;
   assign PSLVERR = pslverr_q;
   assign PRDATA  = prdata_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: instance 0 has two wait states, instance 1 none.
module tb_apb_slave_mem;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        psel    [2];
   logic        pen     [2];
   logic        pwr     [2];
   logic [31:0] paddr   [2];
   logic [31:0] pwdata  [2];
   logic [31:0] prdata  [2];
   logic        pready  [2];
   logic        pslverr [2];

   int n_checks = 0;
   int n_fail   = 0;

   // Reference memory contents, one image per instance.
   logic [31:0] model [2][16];

   always #5 clk = ~clk;

   apb_slave_mem #(.DEPTH(16), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) u_dut_w2 (
      .clk(clk), .PRESETn(rst_n), .PSEL1(psel[0]), .PENABLE(pen[0]),
      .PWRITE(pwr[0]), .PADDR(paddr[0]), .PWDATA(pwdata[0]),
      .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));

   apb_slave_mem #(.DEPTH(16), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u_dut_w0 (
      .clk(clk), .PRESETn(rst_n), .PSEL1(psel[1]), .PENABLE(pen[1]),
      .PWRITE(pwr[1]), .PADDR(paddr[1]), .PWDATA(pwdata[1]),
      .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));

   function automatic int wc(input int d);
      return (d == 0) ? 2 : 0;
   endfunction

   // Error when misaligned or beyond the 16-word window (base 0).
   function automatic bit exp_err(input logic [31:0] a);
      return ((a % 4) != 0) || ((a / 4) >= 16);
   endfunction

   task automatic clear_model();
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 16; i++) model[d][i] = '0;
   endtask

   // One complete transfer, starting 1 time unit after a clock edge and
   // ending 1 time unit after the completion edge with the bus released.
   task automatic xfer(input int d, input bit wr, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd,
                       output logic er, output int waits, output logic rdy_after);
      psel[d] = 1'b1; pen[d] = 1'b0; pwr[d] = wr; paddr[d] = a; pwdata[d] = wd;
      @(posedge clk); #1;
      pen[d] = 1'b1;
      waits = 0;
      while (pready[d] !== 1'b1 && waits < 50) begin
         waits++;
         @(posedge clk); #1;
      end
      rd = prdata[d];
      er = pslverr[d];
      @(posedge clk); #1;
      rdy_after = pready[d];
      psel[d] = 1'b0; pen[d] = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] rd; logic er, ra; int w; int guard;
      rst_n = 1'b0;
      for (int d = 0; d < 2; d++) begin
         psel[d] = 0; pen[d] = 0; pwr[d] = 0; paddr[d] = 0; pwdata[d] = 0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         n_checks++;
         if ({pready[d], pslverr[d], prdata[d]} !== 34'h0) begin
            n_fail++;
            $display("FAIL reset_outputs d%0d: got rdy=%b err=%b data=%h, want 0/0/0",
                     d, pready[d], pslverr[d], prdata[d]);
         end
      end
      rst_n = 1'b1;
      clear_model();

      // Reset in the middle of the WAIT phase.
      xfer(0, 1'b1, 32'h0, 32'h55, rd, er, w, ra);
      model[0][0] = 32'h55;
      psel[0] = 1; pen[0] = 0; pwr[0] = 1; paddr[0] = 32'h0; pwdata[0] = 32'h77;
      @(posedge clk); #1; pen[0] = 1;
      @(posedge clk); #3; rst_n = 1'b0; #1;
      n_checks++;
      if ({pready[0], pslverr[0], prdata[0]} !== 34'h0) begin
         n_fail++;
         $display("FAIL reset_mid_wait: got rdy=%b err=%b data=%h, want 0/0/0",
                  pready[0], pslverr[0], prdata[0]);
      end
      psel[0] = 0; pen[0] = 0;
      @(posedge clk); #1; rst_n = 1'b1;
      clear_model();

      // Reset while PREADY is high (DONE): must clear at once, no write.
      xfer(0, 1'b1, 32'h0, 32'h55, rd, er, w, ra);
      model[0][0] = 32'h55;
      psel[0] = 1; pen[0] = 0; pwr[0] = 1; paddr[0] = 32'h0; pwdata[0] = 32'h77;
      @(posedge clk); #1; pen[0] = 1;
      guard = 0;
      while (pready[0] !== 1'b1 && guard < 50) begin
         guard++;
         @(posedge clk); #1;
      end
      #2; rst_n = 1'b0; #1;
      n_checks++;
      if (pready[0] !== 1'b0 || prdata[0] !== 32'h0 || guard >= 50) begin
         n_fail++;
         $display("FAIL reset_mid_done: got rdy=%b data=%h guard=%0d, want rdy=0 data=0",
                  pready[0], prdata[0], guard);
      end
      psel[0] = 0; pen[0] = 0;
      @(posedge clk); #1; rst_n = 1'b1;
      clear_model();

      for (int d = 0; d < 2; d++) begin
         xfer(d, 1'b0, 32'h0, 32'h0, rd, er, w, ra);
         n_checks++;
         if (rd !== 32'h0 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_word0 d%0d: got data=%h err=%b, want 0/0", d, rd, er);
         end
      end
   endtask

   task automatic test_wait2();
      logic [31:0] rd; logic er, ra; int w;
      xfer(0, 1'b1, 32'h8, 32'hDEADBEEF, rd, er, w, ra);
      model[0][2] = 32'hDEADBEEF;
      n_checks++;
      if (w != 2 || er !== 1'b0 || rd !== 32'h0 || ra !== 1'b0) begin
         n_fail++;
         $display("FAIL wait2_write: got waits=%0d err=%b data=%h rdy_after=%b, want 2/0/0/0",
                  w, er, rd, ra);
      end
      xfer(0, 1'b0, 32'h8, 32'h0, rd, er, w, ra);
      n_checks++;
      if (w != 2 || er !== 1'b0 || rd !== 32'hDEADBEEF || ra !== 1'b0) begin
         n_fail++;
         $display("FAIL wait2_read: got waits=%0d err=%b data=%h rdy_after=%b, want 2/0/deadbeef/0",
                  w, er, rd, ra);
      end
   endtask

   task automatic test_zero_wait_b2b();
      logic [31:0] rd; logic er, ra; int w;
      // Second call starts in the same time step the first one released the bus.
      xfer(1, 1'b1, 32'h4, 32'h1234, rd, er, w, ra);
      model[1][1] = 32'h1234;
      n_checks++;
      if (w != 0 || er !== 1'b0 || ra !== 1'b0) begin
         n_fail++;
         $display("FAIL zw_write: got waits=%0d err=%b rdy_after=%b, want 0/0/0", w, er, ra);
      end
      xfer(1, 1'b0, 32'h4, 32'h0, rd, er, w, ra);
      n_checks++;
      if (w != 0 || er !== 1'b0 || rd !== 32'h1234) begin
         n_fail++;
         $display("FAIL zw_b2b_read: got waits=%0d err=%b data=%h, want 0/0/1234", w, er, rd);
      end
   endtask

   task automatic test_errors();
      logic [31:0] rd; logic er, ra; int w;
      for (int d = 0; d < 2; d++) begin
         xfer(d, 1'b1, 32'h40, 32'hA5A5A5A5, rd, er, w, ra);
         n_checks++;
         if (er !== 1'b1 || rd !== 32'h0 || w != wc(d)) begin
            n_fail++;
            $display("FAIL err_write_range d%0d: got err=%b data=%h waits=%0d, want 1/0/%0d",
                     d, er, rd, w, wc(d));
         end
         xfer(d, 1'b0, 32'h6, 32'h0, rd, er, w, ra);
         n_checks++;
         if (er !== 1'b1 || rd !== 32'h0) begin
            n_fail++;
            $display("FAIL err_read_misaligned d%0d: got err=%b data=%h, want 1/0", d, er, rd);
         end
         xfer(d, 1'b0, 32'h0, 32'h0, rd, er, w, ra);
         n_checks++;
         if (er !== 1'b0 || rd !== model[d][0]) begin
            n_fail++;
            $display("FAIL err_word0_intact d%0d: got err=%b data=%h, want 0/%h",
                     d, er, rd, model[d][0]);
         end
      end
   endtask

   task automatic test_abort();
      logic [31:0] rd; logic er, ra; int w; int pulses;
      xfer(0, 1'b1, 32'hC, 32'h11111111, rd, er, w, ra);
      model[0][3] = 32'h11111111;
      psel[0] = 1; pen[0] = 0; pwr[0] = 1; paddr[0] = 32'hC; pwdata[0] = 32'h22222222;
      @(posedge clk); #1; pen[0] = 1;
      @(posedge clk); #1;
      psel[0] = 0; pen[0] = 0;
      pulses = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (pready[0] === 1'b1) pulses++;
      end
      n_checks++;
      if (pulses != 0) begin
         n_fail++;
         $display("FAIL abort_no_ready: got %0d PREADY cycles, want 0", pulses);
      end
      // Access strobe with no setup phase must be ignored.
      psel[0] = 1; pen[0] = 1; pwr[0] = 1; paddr[0] = 32'hC; pwdata[0] = 32'h33333333;
      pulses = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (pready[0] === 1'b1) pulses++;
      end
      psel[0] = 0; pen[0] = 0;
      n_checks++;
      if (pulses != 0) begin
         n_fail++;
         $display("FAIL no_setup_ignored: got %0d PREADY cycles, want 0", pulses);
      end
      @(posedge clk); #1;
      xfer(0, 1'b0, 32'hC, 32'h0, rd, er, w, ra);
      n_checks++;
      if (rd !== model[0][3] || er !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_mem_intact: got data=%h err=%b, want %h/0", rd, er, model[0][3]);
      end
   endtask

   task automatic test_random();
      logic [31:0] rd, a, wd, exp_rd; logic er, ra, e_err; int w, d; bit wr;
      for (int n = 0; n < 200; n++) begin
         d  = int'($urandom_range(0, 1));
         wr = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 7) == 0) a = 32'($urandom_range(0, 127));
         else a = 32'($urandom_range(0, 15)) * 4;
         wd = $urandom;
         e_err  = exp_err(a);
         exp_rd = (wr || e_err) ? 32'h0 : model[d][a / 4];
         xfer(d, wr, a, wd, rd, er, w, ra);
         if (wr && !e_err) model[d][a / 4] = wd;
         n_checks++;
         if (rd !== exp_rd || er !== e_err || w != wc(d) || ra !== 1'b0) begin
            n_fail++;
            $display("FAIL random[%0d] d%0d %s a=%h: got data=%h err=%b waits=%0d rdy_after=%b, want %h/%b/%0d/0",
                     n, d, wr ? "wr" : "rd", a, rd, er, w, ra, exp_rd, e_err, wc(d));
         end
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
         end
      end
   endtask

   initial begin
      test_reset();
      test_wait2();
      test_zero_wait_b2b();
      test_errors();
      test_abort();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
      $finish;
   end

endmodule
